// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, Rcon table, the
// 128-bit state packing and the GF(2^8) helpers used by the round components.
package aes_pkg;

  localparam int AES_NR   = 10;
  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  // Entry 0 is unused; rounds 1..10 index directly.
  localparam logic [7:0] RCON_TAB [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Byte (col, row) lives at bits [32*col + 8*row +: 8]; FIPS byte n = col n/4, row n%4.
  function automatic int byte_lsb(input int col, input int row);
    return WORD_W * col + BYTE_W * row;
  endfunction

  function automatic logic [7:0] rcon_lookup(input logic [CNT_W-1:0] round);
    logic [7:0] r;
    r = 8'h00;
    if (round >= 4'd1 && round <= 4'd10) r = RCON_TAB[round];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = x;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: current round key plus Rcon in, next round key out.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [7:0]         rcon,
  output logic [BLOCK_W-1:0] key_out
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w3, sub_w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = key_in[31:0];
  assign w1 = key_in[63:32];
  assign w2 = key_in[95:64];
  assign w3 = key_in[127:96];

  // Byte 0 of the word sits in [7:0], so RotWord moves it to the top.
  assign rot_w3 = {w3[7:0], w3[31:8]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    assign sub_w3[BYTE_W*b +: BYTE_W] = sbox(rot_w3[BYTE_W*b +: BYTE_W]);
  end

  assign n0 = w0 ^ sub_w3 ^ {24'h000000, rcon};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n3, n2, n1, n0};

endmodule

// File: rtl/mixcolumns.sv
// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant matrix.
module mixcolumns
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[byte_lsb(c, 0) +: BYTE_W];
    assign a1 = din[byte_lsb(c, 1) +: BYTE_W];
    assign a2 = din[byte_lsb(c, 2) +: BYTE_W];
    assign a3 = din[byte_lsb(c, 3) +: BYTE_W];

    assign dout[byte_lsb(c, 0) +: BYTE_W] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout[byte_lsb(c, 1) +: BYTE_W] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout[byte_lsb(c, 2) +: BYTE_W] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout[byte_lsb(c, 3) +: BYTE_W] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/shiftrows.sv
// ShiftRows: row r of the state is rotated left by r columns.
module shiftrows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      localparam int DST = byte_lsb(c, r);
      localparam int SRC = byte_lsb((c + r) % NUM_COLS, r);
      assign dout[DST +: BYTE_W] = din[SRC +: BYTE_W];
    end
  end

endmodule

// File: rtl/subbytes.sv
// SubBytes: S-box applied to each of the 16 state bytes.
module subbytes
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[BYTE_W*i +: BYTE_W] = sbox(din[BYTE_W*i +: BYTE_W]);
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, key schedule computed on the fly.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BLOCK_W-1:0]  plaintext,
  input  logic [BLOCK_W-1:0]  key,
  output logic                busy,
  output logic                done,
  output logic [BLOCK_W-1:0]  ciphertext
);

  localparam logic [CNT_W-1:0] LAST_MID = CNT_W'(NR - 1);

  aes_state_e         state_q, state_d;
  logic [CNT_W-1:0]   round_q, round_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] rk_q, rk_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;

  logic [BLOCK_W-1:0] sb_out, sr_out, mc_out, k_next;
  logic [7:0]         rcon_v;

  subbytes   u_sub (.din(blk_q),  .dout(sb_out));
  shiftrows  u_sr  (.din(sb_out), .dout(sr_out));
  mixcolumns u_mc  (.din(sr_out), .dout(mc_out));

  assign rcon_v = rcon_lookup(round_q);

  aes_key_step u_ks (
    .key_in  (rk_q),
    .rcon    (rcon_v),
    .key_out (k_next)
  );

  // Handshake: start is a request sampled only in IDLE; busy covers the
  // ROUND/FINAL cycles, done is a one-cycle pulse, and requests made while not
  // IDLE are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d   = mc_out ^ k_next;
        rk_d    = k_next;
        round_d = round_q + 4'd1;
        if (round_q == LAST_MID) state_d = FINAL;
      end
      FINAL: begin
        blk_d   = sr_out ^ k_next;
        ct_d    = sr_out ^ k_next;
        rk_d    = k_next;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
    end
  end

  assign busy       = (state_q == ROUND) || (state_q == FINAL);
  assign done       = (state_q == DONE);
  assign ciphertext = ct_q;

endmodule

// File: doc/aes_enc_ctrl.md
AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of AES rounds; only 10 (AES-128) is legal.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to encrypt; sampled only in IDLE.
REQ-005 Port: plaintext  input  128  input block; sampled with an accepted start.
REQ-006 Port: key  input  128  cipher key; sampled with an accepted start.
REQ-007 Port: busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 Port: done  output  1  one-cycle pulse when ciphertext becomes valid.
REQ-009 Port: ciphertext  output  128  registered result; valid from done and held until the next accepted start.
REQ-010 All 128-bit buses use the shared state packing: column c in bits [32c+31:32c]; row r of that column in [32c+8r+7:32c+8r]. FIPS-197 byte 0 is therefore bits [7:0].

Function
REQ-011 The FSM SHALL have exactly the states IDLE, ROUND, FINAL and DONE.
REQ-012 IDLE, when start=1 at the clock edge:
  - state register <= plaintext ^ key
  - round key register <= key
  - round counter <= 1
  - next state ROUND
REQ-013 IDLE with start=0 SHALL hold all registers.
REQ-014 ROUND, each cycle: state <= MixColumns(ShiftRows(SubBytes(state))) ^ K; K is the next round key.
REQ-015 K SHALL be derived combinationally from the round key register and Rcon[round]; the round key register <= K in the same edge.
REQ-016 ROUND SHALL increment the counter and go to FINAL when the counter reaches NR-1 at that edge.
REQ-017 FINAL (round NR), one cycle:
  - state <= ShiftRows(SubBytes(state)) ^ K, with no MixColumns
  - ciphertext <= same value
  - next state DONE
REQ-018 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: the accepting edge is edge 0 and FINAL completes at edge 10, so done is high in the cycle after edge 10 (11 cycles after start sampling).
REQ-020 Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
REQ-021 Key step:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {00,00,00,Rcon}, with Rcon in byte [7:0] of the word
  - wi' = wi ^ w(i-1)' for i = 1..3
  - word i = bits [32i+31:32i]
REQ-022 start asserted in ROUND, FINAL or DONE SHALL be ignored and SHALL NOT queue a request.
REQ-023 plaintext and key changes after acceptance SHALL NOT affect the running encryption.
REQ-024 start held high continuously SHALL produce back-to-back encryptions, each accepted in the IDLE cycle after DONE.
REQ-025 busy SHALL be 1 in ROUND and FINAL, and 0 in IDLE and DONE.

Reset
REQ-026 rst=1 SHALL immediately force:
  - FSM to IDLE
  - busy=0, done=0
  - ciphertext, state register, round key register and round counter to 0
REQ-027 rst asserted mid-encryption SHALL abort the operation; no done SHALL be produced for the aborted block.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-029 Shared package aes_pkg SHALL hold:
  - FSM state encoding
  - NR
  - the Rcon table
  - the state packing/byte-index constants
REQ-030 The block SHALL instantiate the existing subbytes, shiftrows and mixcolumns round components for the state path.
REQ-031 One sub-module, aes_key_step (combinational, 128-bit key plus 8-bit Rcon in, next round key out), SHALL implement REQ-021.
REQ-032 Only the FSM, the round counter and the 3x128-bit registers SHALL be sequential; no other storage.

Verification
REQ-033 FIPS-197 C.1:
  - plaintext=128'hffeeddccbbaa99887766554433221100, key=128'h0f0e0d0c0b0a09080706050403020100, start one cycle
  - required: ciphertext=128'h5ac5b47080b7cdd830047b6ad8e0c469 with done in the 11th cycle after acceptance
REQ-034 FIPS-197 Appendix B:
  - key=2b7e1516... and input=3243f6a8..., both packed per REQ-010
  - required: output 3925841d02dc09fbdc118597196a0b32, packed per REQ-010
REQ-035 start pulsed at cycles 3, 7 and 10 after acceptance, with plaintext changed each time
  - required: a single done with the original result; busy stays 1 throughout
REQ-036 rst asserted at cycle 5 of an encryption
  - required: busy=0 and ciphertext=0 immediately; no done pulse
  - a new start then yields the correct result
REQ-037 start held high for 3 encryptions
  - required: done pulses exactly 12 cycles apart, each ciphertext correct
REQ-038 Idle check: with start=0 for 20 cycles after reset, done=0, busy=0 and ciphertext=0 throughout.
